// File: rtl/qdec_pkg.sv
// Shared quadrature state encoding ({A,B}) and the up-order successor helper
// used by the decoder and its input filter.
package qdec_pkg;

    typedef logic [1:0] qstate_t;

    localparam qstate_t QS_00 = 2'b00;
    localparam qstate_t QS_10 = 2'b10;
    localparam qstate_t QS_11 = 2'b11;
    localparam qstate_t QS_01 = 2'b01;

    localparam int unsigned FILTER_LEN_MAX = 32'd16;

    // Up order is 00 -> 10 -> 11 -> 01 -> 00; down is the same walk reversed.
    function automatic qstate_t qdec_next_up(input qstate_t state);
        qstate_t nxt;
        case (state)
            QS_00:   nxt = QS_10;
            QS_10:   nxt = QS_11;
            QS_11:   nxt = QS_01;
            QS_01:   nxt = QS_00;
            default: nxt = QS_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/qdec_input_filter.sv
// Two-flop synchroniser plus stability filter for the 2-bit {A,B} encoder lines;
// strobes o_accept on the edge where a new level has held FILTER_LEN samples.
module qdec_input_filter
    import qdec_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 32'd4
)
(
    input  logic    clk,
    input  logic    reset_n,
    input  qstate_t i_raw,
    output qstate_t o_sync,
    output logic    o_sync_vld,
    output qstate_t o_filt,
    output logic    o_accept
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 32'd1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 32'd1);

    qstate_t       r_meta;
    qstate_t       r_sync;
    qstate_t       r_sync_prev;
    qstate_t       r_filt;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_fill;
    logic [CW-1:0] w_run;
    logic          w_accept;

    // Run length of the current sync value, counting this edge as sample zero.
    always_comb begin
        w_run    = '0;
        w_accept = 1'b0;
        if (r_sync == r_sync_prev) begin
            w_run = r_cnt + CW'(1);
        end else begin
            w_run = '0;
        end
        w_accept = (r_sync != r_filt) && (w_run == LAST);
    end

    // Synchroniser, fill tracker, stability counter and filtered state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta      <= QS_00;
            r_sync      <= QS_00;
            r_sync_prev <= QS_00;
            r_filt      <= QS_00;
            r_cnt       <= '0;
            r_fill      <= 2'b00;
        end else begin
            r_meta      <= i_raw;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            r_fill      <= {r_fill[0], 1'b1};
            r_cnt       <= (r_sync == r_filt) ? '0 : w_run;
            if (w_accept) begin
                r_filt <= r_sync;
            end
        end
    end

    assign o_sync     = r_sync;
    // Sync holds a genuinely sampled level only once both flops refilled after reset.
    assign o_sync_vld = r_fill[1];
    assign o_filt     = r_filt;
    assign o_accept   = w_accept;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: filtered {A,B} decode into step_en/step_up with a
// sticky illegal-transition flag. Define QDEC_X4_EN for x4 decoding (default x1).
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 32'd4
)
(
    input  logic clk,
    input  logic reset_n,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step_en,
    output logic step_up,
    output logic err
);

    qstate_t w_sync;
    qstate_t w_filt;
    logic    w_sync_vld;
    logic    w_accept;
    logic    w_is_up;
    logic    w_is_down;
    logic    w_counts;
    logic    w_step;
    logic    w_illegal;
    logic    r_init_done;

    qdec_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_raw      ({a_in, b_in}),
        .o_sync     (w_sync),
        .o_sync_vld (w_sync_vld),
        .o_filt     (w_filt),
        .o_accept   (w_accept)
    );

    // Classify the accepted transition from the old filtered state to the new one.
    always_comb begin
        w_is_up   = (w_sync == qdec_next_up(w_filt));
        w_is_down = (w_filt == qdec_next_up(w_sync));
`ifdef QDEC_X4_EN
        w_counts  = 1'b1;
`else
        // x1: only arrivals at 00 count, so one step per full encoder cycle.
        w_counts  = (w_sync == QS_00);
`endif
        w_step    = w_accept && r_init_done && (w_is_up || w_is_down) && w_counts;
        w_illegal = w_accept && r_init_done && !w_is_up && !w_is_down;
    end

    // Initial capture, registered step outputs and the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init_done <= 1'b0;
            step_en     <= 1'b0;
            step_up     <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (!r_init_done && (w_accept || (w_sync_vld && (w_sync == QS_00)))) begin
                r_init_done <= 1'b1;
            end
            step_en <= w_step;
            if (w_step) begin
                step_up <= w_is_up;
            end
            if (w_illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomised plus directed bench for quadrature_decoder: a sample-history reference
// model feeds an expectation queue that a negedge monitor drains and compares.
module tb_quadrature_decoder;

    localparam int FL = 4;
`ifdef QDEC_X4_EN
    localparam bit X4 = 1'b1;
`else
    localparam bit X4 = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic a_in = 1'b1;
    logic b_in = 1'b1;
    logic err_clr = 1'b0;
    logic step_en;
    logic step_up;
    logic err;

    typedef struct { int cyc; bit up; } exp_t;
    exp_t       exp_q[$];
    logic [1:0] hist[$];
    int         n = 0;
    bit         m_init = 1'b0;
    logic [1:0] m_filt = 2'b00;
    bit         m_err = 1'b0;
    bit         m_up = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         last_step_n = -1;

    quadrature_decoder #(.FILTER_LEN(FL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .err_clr (err_clr),
        .step_en (step_en),
        .step_up (step_up),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Position around the encoder cycle: 00,10,11,01 -> 0,1,2,3.
    function automatic int qpos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Reference model: sync at edge k is the input sampled at edge k-2.
    always @(posedge clk) begin : model
        logic [1:0] sv;
        int run, idx, d;
        bit acc, ill, stp;
        if (!reset_n) begin
            hist = '{2'b00, 2'b00};
            n = 0; m_init = 1'b0; m_filt = 2'b00; m_err = 1'b0; m_up = 1'b0;
        end else begin
            n++;
            hist.push_back({a_in, b_in});
            if (hist.size() > 64) void'(hist.pop_front());
            sv = hist[hist.size() - 3];
            run = 0;
            idx = hist.size() - 3;
            while (idx >= 0 && hist[idx] == sv) begin run++; idx--; end
            acc = (sv != m_filt) && (run >= FL);
            ill = 1'b0;
            if (!m_init) begin
                if (n >= 3 && sv == 2'b00) m_init = 1'b1;
                else if (acc) begin m_filt = sv; m_init = 1'b1; end
            end else if (acc) begin
                d = (qpos(sv) - qpos(m_filt) + 4) % 4;
                if (d == 2) ill = 1'b1;
                else begin
                    stp = X4 ? 1'b1 : (sv == 2'b00);
                    if (stp) begin
                        exp_q.push_back('{cyc: n, up: (d == 1)});
                        m_up = (d == 1);
                    end
                end
                m_filt = sv;
            end
            if (ill) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    // Monitor: compare outputs mid-cycle against the model's expectations.
    always @(negedge clk) begin : monitor
        bit e;
        if (!reset_n) begin
            chk("rst_step_en", step_en, 0);
            chk("rst_step_up", step_up, 0);
            chk("rst_err", err, 0);
            exp_q.delete();
        end else begin
            e = (exp_q.size() > 0) && (exp_q[0].cyc == n);
            chk("step_en", step_en, e);
            if (e) begin
                chk("step_dir", step_up, exp_q[0].up);
                void'(exp_q.pop_front());
            end
            if (step_en) begin pulses++; last_step_n = n; end
            chk("err", err, m_err);
            chk("step_up_lvl", step_up, m_up);
        end
    end

    task automatic drive(input logic [1:0] v);
        a_in = v[1];
        b_in = v[0];
    endtask

    task automatic wait_cyc(input int c);
        repeat (c) @(posedge clk);
        #2;
    endtask

    task automatic seg(input logic [1:0] v, input bit want, input bit want_up, input string nm);
        int n0, c0;
        n0 = n;
        c0 = pulses;
        drive(v);
        wait_cyc(10);
        chk({nm, "_cnt"}, pulses - c0, want ? 1 : 0);
        if (want) begin
            chk({nm, "_lat"}, last_step_n - n0, FL + 2);
            chk({nm, "_dir"}, step_up, want_up);
        end
    endtask

    initial begin : stim
        int c0, len;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(30);
        chk("init_err", err, 0);
        chk("init_up", step_up, 0);
        chk("init_cnt", pulses, 0);

        seg(2'b01, X4, 1'b1, "g01");
        seg(2'b00, 1'b1, 1'b1, "g00");

        seg(2'b10, X4, 1'b1, "u10");
        seg(2'b11, X4, 1'b1, "u11");
        seg(2'b01, X4, 1'b1, "u01");
        seg(2'b00, 1'b1, 1'b1, "u00");

        seg(2'b01, X4, 1'b0, "d01");
        seg(2'b11, X4, 1'b0, "d11");
        seg(2'b10, X4, 1'b0, "d10");
        seg(2'b00, 1'b1, 1'b0, "d00");

        c0 = pulses;
        drive(2'b10);
        wait_cyc(FL - 1);
        drive(2'b00);
        wait_cyc(12);
        chk("glitch_cnt", pulses - c0, 0);
        chk("glitch_err", err, 0);

        c0 = pulses;
        drive(2'b11);
        wait_cyc(10);
        chk("ill_err", err, 1);
        chk("ill_cnt", pulses - c0, 0);
        drive(2'b00);
        wait_cyc(FL + 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        wait_cyc(5);
        chk("clr_same_edge", err, 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        chk("clr_alone", err, 0);
        drive(2'b11);
        wait_cyc(10);
        chk("ill2_err", err, 1);

        drive(2'b01);
        wait_cyc(3);
        reset_n = 1'b0;
        #1;
        chk("midrst_en", step_en, 0);
        chk("midrst_up", step_up, 0);
        chk("midrst_err", err, 0);
        wait_cyc(2);
        reset_n = 1'b1;
        c0 = pulses;
        wait_cyc(15);
        chk("postrst_cnt", pulses - c0, 0);
        chk("postrst_err", err, 0);

        for (int s = 0; s < 60; s++) begin
            drive(2'($urandom_range(0, 3)));
            len = $urandom_range(1, 2 * FL + 2);
            for (int k = 0; k < len; k++) begin
                err_clr = ($urandom_range(0, 7) == 0);
                wait_cyc(1);
            end
        end
        err_clr = 1'b0;
        wait_cyc(20);
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
